pipe_reg_de_hs: RTL and testbench
=================================

# pipe_reg_de_hs

Parametrised decode-to-execute pipeline stage register with valid/ready handshaking, synchronous flush and an optional skid entry. It sits between the decode and execute stages of the vector/scalar core. It carries LANES-wide operand vectors plus an immediate, a packed control bundle, the destination address and the vector/scalar flag. The bubble/stall control that a plain D-to-E register does not provide lives here.

## Interface
- LANES, 16, number of operand lanes per source operand
- DATA_W, 32, bits per lane and width of the immediate
- CTRL_W, 16, width of the packed control bundle (PCSrc, RegWrite, MemWrite, ALUControl, ...)
- ADDR_W, 4, destination register address width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- FLUSH  in  1  synchronous kill of every held beat
- valid_d  in  1  decode presents a beat
- ready_d  out  1  stage can accept a beat this cycle
- rd1_d, rd2_d  in  LANES*DATA_W  source operand vectors, lane 0 in the LSBs
- imm_d  in  DATA_W  extended immediate
- ctrl_d  in  CTRL_W  control bundle
- wa3_d  in  ADDR_W  destination address
- vs_d  in  1  1 = vector instruction, 0 = scalar
- valid_e  out  1  execute-side beat valid
- ready_e  in  1  execute consumes the beat this cycle
- rd1_e, rd2_e, imm_e, ctrl_e, wa3_e, vs_e  out  same widths as the _d inputs  registered payload

## Operation
- A transfer in occurs when valid_d && ready_d at a rising edge. A transfer out occurs when valid_e && ready_e.
- The main entry holds the payload seen on the _e outputs. Its valid flag drives valid_e.
- Payload outputs hold their value while valid_e && !ready_e (stall). The payload must not change under a stall.
- When valid_e = 0, ctrl_e is forced to all zeros. A bubble therefore never asserts RegWrite, MemWrite or branch. The other payload outputs are don't-care.
- FLUSH has the highest priority.
  - At the edge it clears every valid flag, main and skid.
  - A beat offered in the same cycle is discarded. Upstream treats it as accepted if ready_d was high.
- Without FLUSH, the main entry follows these rules:
  - Empty: loads on a transfer in.
  - Full and ready_e: loads the next beat (from skid if occupied, otherwise from the input) or empties.
  - Full and !ready_e: holds.
- Skid entry (only with PIPE_REG_DE_SKID_EN):
  - It captures an incoming beat when the main entry is full and not being consumed.
  - It drains into main on the next consume.
  - ready_d = !skid_valid, taken straight from a flop.
- Each beat is passed through unchanged. No lane reordering and no width conversion.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on the _e outputs after edge N.
- Throughput is 1 beat/cycle while ready_e = 1.
- Reset values: valid_e = 0; rd1_e, rd2_e, imm_e, ctrl_e, wa3_e, vs_e = 0; skid_valid = 0; ready_d = 1.
- RST asserted mid-stall drops all held beats immediately, without waiting for an edge.
- Full pipeline (main plus skid occupied) gives ready_d = 0. ready_d returns to 1 the cycle after the first consume.
- Consume and accept in the same cycle: the beats keep their order and none are lost or duplicated.
- FLUSH together with ready_e: the beat on the outputs counts as consumed. The stage is empty after the edge.

## Configuration
- PIPE_REG_DE_SKID_EN defined:
  - A two-entry design (main plus skid).
  - ready_d is registered, so there is no combinational path from ready_e to ready_d.
  - Full throughput is kept across a one-cycle downstream stall.
- PIPE_REG_DE_SKID_EN undefined:
  - A single entry only.
  - ready_d = !valid_e || ready_e, a combinational path.
  - All other behaviour is identical.

## Test plan
- Reset, then stream 8 beats with ready_e = 1 -> each beat appears 1 cycle after acceptance, in order, and valid_e stays high throughout.
- Hold ready_e = 0 for 3 cycles with beat A = rd1 lane0 0xDEADBEEF on the outputs -> the outputs stay 0xDEADBEEF.
  - Skid build: ready_d drops after 1 more accept.
  - No-skid build: ready_d = 0 throughout.
  - After release, A then B emerge with no loss.
- Pulse FLUSH with valid_e = 1 and the skid full -> valid_e = 0 and ctrl_e = 0 next cycle, and ready_d = 1. The beat offered during FLUSH never appears.
- Feed a bubble (valid_d = 0) between beats whose ctrl_d = 0xFFFF -> during the bubble ctrl_e = 0x0000 and valid_e = 0.
- Assert RST asynchronously between edges with 2 beats held -> valid_e and all outputs drop to 0 immediately, and ready_d = 1.
- Skid build only: a random ready_e/valid_d pattern over 1000 cycles compared against a reference FIFO model -> identical output sequence, and ready_d never depends combinationally on ready_e.

Source files
------------

// File: rtl/pipe_reg_de_hs.sv
// Decode-to-execute pipeline register with valid/ready handshake, synchronous flush
// and an optional skid entry (enabled by defining PIPE_REG_DE_SKID_EN).
module pipe_reg_de_hs #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      FLUSH,
  input  logic                      valid_d,
  output logic                      ready_d,
  input  logic [LANES*DATA_W-1:0]   rd1_d,
  input  logic [LANES*DATA_W-1:0]   rd2_d,
  input  logic [DATA_W-1:0]         imm_d,
  input  logic [CTRL_W-1:0]         ctrl_d,
  input  logic [ADDR_W-1:0]         wa3_d,
  input  logic                      vs_d,
  output logic                      valid_e,
  input  logic                      ready_e,
  output logic [LANES*DATA_W-1:0]   rd1_e,
  output logic [LANES*DATA_W-1:0]   rd2_e,
  output logic [DATA_W-1:0]         imm_e,
  output logic [CTRL_W-1:0]         ctrl_e,
  output logic [ADDR_W-1:0]         wa3_e,
  output logic                      vs_e
);

  typedef struct packed {
    logic [LANES*DATA_W-1:0] rd1;
    logic [LANES*DATA_W-1:0] rd2;
    logic [DATA_W-1:0]       imm;
    logic [CTRL_W-1:0]       ctrl;
    logic [ADDR_W-1:0]       wa3;
    logic                    vs;
  } beat_t;

  beat_t in_beat;
  beat_t main_q, main_d;
  logic  main_valid_q, main_valid_d;

  assign in_beat = {rd1_d, rd2_d, imm_d, ctrl_d, wa3_d, vs_d};

`ifdef PIPE_REG_DE_SKID_EN
  beat_t skid_q, skid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  xfer_in;

  // ready_d comes straight from a flop, so ready_e never reaches it combinationally.
  assign ready_d = !skid_valid_q;
  assign xfer_in = valid_d && ready_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (FLUSH) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || ready_e) begin
      // Skid only fills while main is full, so an occupied skid always drains first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = xfer_in;
        if (xfer_in) main_d = in_beat;
      end
    end else if (xfer_in) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) skid_valid_q <= 1'b0;
    else     skid_valid_q <= skid_valid_d;
  end

  // NOTE: the skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    skid_q <= skid_d;
  end
`else
  assign ready_d = !main_valid_q || ready_e;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (FLUSH) begin
      main_valid_d = 1'b0;
    end else if (ready_d) begin
      main_valid_d = valid_d;
      if (valid_d) main_d = in_beat;
    end
  end
`endif

  // Visible payload resets to zero so the outputs are clean straight out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
    end
  end

  assign valid_e = main_valid_q;
  assign rd1_e   = main_q.rd1;
  assign rd2_e   = main_q.rd2;
  assign imm_e   = main_q.imm;
  // A bubble must never carry live control bits downstream.
  assign ctrl_e  = main_valid_q ? main_q.ctrl : '0;
  assign wa3_e   = main_q.wa3;
  assign vs_e    = main_q.vs;

endmodule

// File: tb/tb_pipe_reg_de_hs.sv
// Directed self-checking bench for pipe_reg_de_hs; covers both builds via PIPE_REG_DE_SKID_EN.
module tb_pipe_reg_de_hs;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [LANES*DATA_W-1:0] rd1;
    logic [LANES*DATA_W-1:0] rd2;
    logic [DATA_W-1:0]       imm;
    logic [CTRL_W-1:0]       ctrl;
    logic [ADDR_W-1:0]       wa3;
    logic                    vs;
  } beat_t;

  localparam int BW = $bits(beat_t);

  logic                    CLK = 1'b0;
  logic                    RST;
  logic                    FLUSH;
  logic                    valid_d;
  logic                    ready_d;
  logic [LANES*DATA_W-1:0] rd1_d, rd2_d;
  logic [DATA_W-1:0]       imm_d;
  logic [CTRL_W-1:0]       ctrl_d;
  logic [ADDR_W-1:0]       wa3_d;
  logic                    vs_d;
  logic                    valid_e;
  logic                    ready_e;
  logic [LANES*DATA_W-1:0] rd1_e, rd2_e;
  logic [DATA_W-1:0]       imm_e;
  logic [CTRL_W-1:0]       ctrl_e;
  logic [ADDR_W-1:0]       wa3_e;
  logic                    vs_e;

  int checks = 0;
  int errors = 0;

  pipe_reg_de_hs #(.LANES(LANES), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .valid_d(valid_d), .ready_d(ready_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .ctrl_d(ctrl_d), .wa3_d(wa3_d), .vs_d(vs_d),
    .valid_e(valid_e), .ready_e(ready_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .ctrl_e(ctrl_e), .wa3_e(wa3_e), .vs_e(vs_e)
  );

  always #5 CLK = ~CLK;

  function automatic beat_t mk(int n);
    beat_t b;
    for (int i = 0; i < LANES; i++) begin
      b.rd1[i*DATA_W +: DATA_W] = DATA_W'(n * 256 + i);
      b.rd2[i*DATA_W +: DATA_W] = ~DATA_W'(n * 256 + i);
    end
    b.imm  = DATA_W'(n) ^ 32'hA5A5_0000;
    b.ctrl = CTRL_W'(n) | 16'h0100;
    b.wa3  = ADDR_W'(n);
    b.vs   = 1'((n >> 1) & 1);
    return b;
  endfunction

  function automatic beat_t obs();
    return {rd1_e, rd2_e, imm_e, ctrl_e, wa3_e, vs_e};
  endfunction

  task automatic drive(input beat_t b, input logic v);
    {rd1_d, rd2_d, imm_d, ctrl_d, wa3_d, vs_d} = b;
    valid_d = v;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] o, input logic [BW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_beat(input string tag, input beat_t e);
    check({tag, ".valid"}, BW'(valid_e), BW'(1'b1));
    check({tag, ".payload"}, obs(), e);
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"}, BW'(valid_e), BW'(1'b0));
    check({tag, ".ctrl"}, BW'(ctrl_e), BW'(0));
  endtask

  beat_t a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b;
`ifdef PIPE_REG_DE_SKID_EN
  beat_t q[$];
  beat_t rb;
  logic  rv, rr, rdy0, acc, con;
`endif

  initial begin
    RST = 1'b1; FLUSH = 1'b0; ready_e = 1'b0;
    drive(mk(0), 1'b0);

    // Reset state
    #12;
    check("reset.valid_e", BW'(valid_e), BW'(0));
    check("reset.payload", obs(), '0);
    check("reset.ready_d", BW'(ready_d), BW'(1));
    #5 RST = 1'b0;
    tick();

    // Stream 8 beats at full throughput
    ready_e = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(mk(k), 1'b1);
      #1 check($sformatf("stream%0d.ready_d", k), BW'(ready_d), BW'(1));
      tick();
      check_beat($sformatf("stream%0d", k), mk(k));
    end
    drive(mk(99), 1'b0);
    tick();
    check_empty("stream_end");

    // Three-cycle stall with A on the outputs, B offered
    a_b = mk(20);
    a_b.rd1[DATA_W-1:0] = 32'hDEAD_BEEF;
    b_b = mk(21);
    drive(a_b, 1'b1);
    tick();
    check_beat("stallA.load", a_b);
    ready_e = 1'b0;
    drive(b_b, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef PIPE_REG_DE_SKID_EN
      check($sformatf("stall%0d.ready_d", i), BW'(ready_d), BW'(i == 0));
`else
      check($sformatf("stall%0d.ready_d", i), BW'(ready_d), BW'(0));
`endif
      tick();
      check_beat($sformatf("stall%0d.A", i), a_b);
      check($sformatf("stall%0d.lane0", i), BW'(rd1_e[DATA_W-1:0]), BW'(32'hDEAD_BEEF));
`ifdef PIPE_REG_DE_SKID_EN
      if (i == 0) valid_d = 1'b0;
`endif
    end
    ready_e = 1'b1;
    #1;
`ifdef PIPE_REG_DE_SKID_EN
    check("release.ready_d", BW'(ready_d), BW'(0));
`else
    check("release.ready_d", BW'(ready_d), BW'(1));
`endif
    tick();
    check_beat("release.B", b_b);
    valid_d = 1'b0;
    #1 check("release.ready_back", BW'(ready_d), BW'(1));
    tick();
    check_empty("release.drained");

    // Flush with a held beat (and full skid in the skid build)
    c_b = mk(30); d_b = mk(31); e_b = mk(32);
    drive(c_b, 1'b1);
    tick();
    check_beat("flush.C", c_b);
    ready_e = 1'b0;
    drive(d_b, 1'b1);
    tick();
    check_beat("flush.C_held", c_b);
    #1 check("flush.full_ready_d", BW'(ready_d), BW'(0));
    drive(e_b, 1'b1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    valid_d = 1'b0;
    check_empty("flush.after");
    #1 check("flush.ready_d", BW'(ready_d), BW'(1));
    ready_e = 1'b1;
    tick();
    check_empty("flush.post1");
    tick();
    check_empty("flush.post2");

    // Bubble between all-ones control beats
    f_b = mk(40); f_b.ctrl = 16'hFFFF;
    g_b = mk(41); g_b.ctrl = 16'hFFFF;
    drive(f_b, 1'b1);
    tick();
    check_beat("bubble.F", f_b);
    drive(g_b, 1'b0);
    tick();
    check_empty("bubble.gap");
    drive(g_b, 1'b1);
    tick();
    check_beat("bubble.G", g_b);
    valid_d = 1'b0;
    tick();
    check_empty("bubble.end");

    // Asynchronous reset while beats are held under a stall
    h_b = mk(50); i_b = mk(51);
    ready_e = 1'b0;
    drive(h_b, 1'b1);
    tick();
    check_beat("areset.H", h_b);
    drive(i_b, 1'b1);
    tick();
    check_beat("areset.H_held", h_b);
    valid_d = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("areset.valid_e", BW'(valid_e), BW'(0));
    check("areset.payload", obs(), '0);
    check("areset.ready_d", BW'(ready_d), BW'(1));
    #3 RST = 1'b0;
    tick();
    check_empty("areset.after");
    ready_e = 1'b1;
    tick();
    check_empty("areset.release");

`ifdef PIPE_REG_DE_SKID_EN
    // Random handshake against a two-deep FIFO reference
    for (int cyc = 0; cyc < 1000; cyc++) begin
      rv = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      rb = mk(1000 + cyc);
      drive(rb, rv);
      ready_e = rr;
      #1;
      rdy0 = ready_d;
      check($sformatf("rand%0d.ready_d", cyc), BW'(ready_d), BW'(q.size() < 2));
      ready_e = !rr;
      #1 check($sformatf("rand%0d.ready_indep", cyc), BW'(ready_d), BW'(rdy0));
      ready_e = rr;
      #1 check($sformatf("rand%0d.valid_e", cyc), BW'(valid_e), BW'(q.size() > 0));
      if (q.size() > 0) check($sformatf("rand%0d.payload", cyc), obs(), q[0]);
      acc = rv && (q.size() < 2);
      con = rr && (q.size() > 0);
      tick();
      if (con) void'(q.pop_front());
      if (acc) q.push_back(rb);
    end
    valid_d = 1'b0;
    ready_e = 1'b1;
    tick(); tick(); tick();
    check_empty("rand.drained");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
